// File: rtl/multicycle_control_if.sv
// Instruction, memory handshake and datapath control bundle for multicycle_control.
interface multicycle_control_if;
  logic       newInstruction;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       _RegWrite;
  logic       _MemRead;
  logic       _MemWrite;
  logic       _MemToReg;
  logic       _RegDst;
  logic       _ALUSrc;
  logic [1:0] _ALUOp;
  logic       busy;
  logic       done;
  logic       err;

  modport master (
    output newInstruction, opcode, mem_ready,
    input  _RegWrite, _MemRead, _MemWrite, _MemToReg, _RegDst, _ALUSrc, _ALUOp,
    input  busy, done, err
  );

  modport slave (
    input  newInstruction, opcode, mem_ready,
    output _RegWrite, _MemRead, _MemWrite, _MemToReg, _RegDst, _ALUSrc, _ALUOp,
    output busy, done, err
  );
endinterface

// File: rtl/multicycle_control.sv
// Multicycle instruction sequencer: decodes one latched opcode, walks it through
// execute / memory / write-back, and aborts on illegal opcodes or memory timeouts.
//
// state    | meaning
// ---------+----------------------------------------------
// S_IDLE   | waiting for newInstruction
// S_DECODE | legality check of latched opcode
// S_EXEC   | ALU cycle, route by instruction class
// S_MEM_RD | load in progress, waiting for mem_ready
// S_MEM_WR | store in progress, waiting for mem_ready
// S_WB     | register write-back
// S_DONE   | completion pulse
// S_ERR    | abort pulse
module multicycle_control #(
  parameter int MAX_WAIT = 15,
  parameter bit ADDI_EN  = 1'b1
) (
  input logic                 clk,
  input logic                 rst,
  multicycle_control_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_DECODE, S_EXEC, S_MEM_RD, S_MEM_WR, S_WB, S_DONE, S_ERR
  } state_t;

  localparam logic [5:0] OP_R    = 6'd0;
  localparam logic [5:0] OP_ADDI = 6'd8;
  localparam logic [5:0] OP_LW   = 6'd35;
  localparam logic [5:0] OP_SW   = 6'd43;
  localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

  state_t     state, state_nxt;
  logic [5:0] opcode_q;
  logic [7:0] wait_cnt, wait_nxt;
  logic       is_r, is_addi, is_lw, is_sw, legal;

  assign is_r    = (opcode_q == OP_R);
  assign is_addi = (opcode_q == OP_ADDI);
  assign is_lw   = (opcode_q == OP_LW);
  assign is_sw   = (opcode_q == OP_SW);
  assign legal   = is_r | is_lw | is_sw | (is_addi & ADDI_EN);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      opcode_q <= 6'd0;
      wait_cnt <= 8'd0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_nxt;
      if (state == S_IDLE && bus.newInstruction)
        opcode_q <= bus.opcode;
    end
  end

  always_comb begin
    state_nxt = state;
    wait_nxt  = wait_cnt;
    case (state)
      S_IDLE:   if (bus.newInstruction) state_nxt = S_DECODE;
      S_DECODE: state_nxt = legal ? S_EXEC : S_ERR;
      S_EXEC: begin
        wait_nxt = 8'd0;
        if (is_lw)      state_nxt = S_MEM_RD;
        else if (is_sw) state_nxt = S_MEM_WR;
        else            state_nxt = S_WB;
      end
      S_MEM_RD, S_MEM_WR: begin
        // mem_ready wins over a timeout landing on the same edge
        if (bus.mem_ready)
          state_nxt = (state == S_MEM_RD) ? S_WB : S_DONE;
        else if (wait_cnt == WAIT_LAST)
          state_nxt = S_ERR;
        else if (wait_cnt != 8'hFF)
          wait_nxt = wait_cnt + 8'd1;
      end
      S_WB:    state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      S_ERR:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  logic sel_active;
  assign sel_active = (state != S_IDLE) && (state != S_ERR);

  always_comb begin
    bus.busy      = (state != S_IDLE);
    bus.done      = (state == S_DONE);
    bus.err       = (state == S_ERR);
    bus._RegWrite = (state == S_WB);
    bus._MemRead  = (state == S_MEM_RD);
    bus._MemWrite = (state == S_MEM_WR);
    bus._MemToReg = 1'b0;
    bus._RegDst   = 1'b0;
    bus._ALUSrc   = 1'b0;
    bus._ALUOp    = 2'b00;
    if (sel_active) begin
      bus._MemToReg = is_lw;
      bus._RegDst   = is_r;
      bus._ALUSrc   = is_lw | is_sw | is_addi;
      bus._ALUOp    = is_r ? 2'b10 : 2'b00;
    end
  end

endmodule
